// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_pkg
// Purpose  : Shared constants, helper function and mode enum for the
//            parametrised synchronous FIFO (sync_fifo_param) and its benches.
// Revision : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int c_default_data_w = 8;
    localparam int c_default_depth  = 16;

    // Bits needed to hold an occupancy value in the range 0..depth inclusive.
    function automatic int clog2_depth(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Read mode selector: FIFO_STD = registered read, FIFO_FWFT = fall-through.
    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_mem.sv
`default_nettype none
// ============================================================================
// Module   : fifo_mem
// Purpose  : Simple dual-port storage array for the FIFO. One synchronous
//            write port, one asynchronous read port. Contents are not reset.
// Ports    : clk        - write clock
//            i_wr_en    - write strobe
//            i_wr_addr  - write address (0..DEPTH-1)
//            i_wr_data  - write data
//            i_rd_addr  - read address (0..DEPTH-1)
//            o_rd_data  - combinational read data
// Revision : 1.0 - initial release
// ============================================================================
module fifo_mem #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]  i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [WIDTH-1:0]  o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule : fifo_mem
`default_nettype wire

// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_param
// Purpose  : Parametrised single-clock FIFO with occupancy count, registered
//            full/empty/almost flags, overflow/underflow pulses and a
//            selectable standard (FWFT=0) or first-word-fall-through (FWFT=1)
//            read mode.
// Macro    : FIFO_PARITY_EN - stores an even-parity bit per entry and adds
//            the rd_parity_err output.
// Ports    : clk, rst_n (async active-low), wr_en/wr_data (push),
//            rd_en (pop / acknowledge), rd_data/rd_valid (read side),
//            full, almost_full, empty, almost_empty, count (status),
//            overflow/underflow (one-cycle error pulses),
//            rd_parity_err (only with FIFO_PARITY_EN).
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W    = c_default_data_w,
    parameter int DEPTH     = c_default_depth,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_en,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic                          rd_en,
    output logic [DATA_W-1:0]             rd_data,
    output logic                          rd_valid,
    output logic                          full,
    output logic                          almost_full,
    output logic                          empty,
    output logic                          almost_empty,
    output logic [clog2_depth(DEPTH)-1:0] count,
    output logic                          overflow,
    output logic                          underflow
`ifdef FIFO_PARITY_EN
    ,
    output logic                          rd_parity_err
`endif
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w = clog2_depth(DEPTH);
`ifdef FIFO_PARITY_EN
    localparam int c_mem_w = DATA_W + 1;
`else
    localparam int c_mem_w = DATA_W;
`endif

    localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(DEPTH - 1);
    localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_af_cnt   = c_cnt_w'(AF_THRESH);
    localparam logic [c_cnt_w-1:0] c_ae_cnt   = c_cnt_w'(AE_THRESH);

    // Elaboration-time parameter checks.
    if (DATA_W < 1) begin : g_chk_data_w
        $error("sync_fifo_param: DATA_W must be >= 1");
    end
    if (DEPTH < 2) begin : g_chk_depth
        $error("sync_fifo_param: DEPTH must be >= 2");
    end
    if (AF_THRESH < 0 || AF_THRESH > DEPTH) begin : g_chk_af
        $error("sync_fifo_param: AF_THRESH outside 0..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH) begin : g_chk_ae
        $error("sync_fifo_param: AE_THRESH outside 0..DEPTH");
    end

    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w-1:0] w_wr_ptr_next;
    logic [c_ptr_w-1:0] w_rd_ptr_next;
    logic [c_cnt_w-1:0] w_count_next;
    logic               w_wr_acc;
    logic               w_rd_acc;
    logic [c_mem_w-1:0] w_mem_wr;
    logic [c_mem_w-1:0] w_mem_rd;

    // Acceptance uses the registered flags, so a same-cycle pop never makes
    // room for a push on a full FIFO, and a same-cycle push never satisfies
    // a pop on an empty one.
    assign w_wr_acc = wr_en & ~full;
    assign w_rd_acc = rd_en & ~empty;

    // Explicit wrap at DEPTH-1 so non-power-of-two depths work.
    assign w_wr_ptr_next = (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + 1'b1;
    assign w_rd_ptr_next = (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + 1'b1;

    always_comb begin
        w_count_next = count;
        if (w_wr_acc && !w_rd_acc) begin
            w_count_next = count + 1'b1;
        end else if (!w_wr_acc && w_rd_acc) begin
            w_count_next = count - 1'b1;
        end
    end

    // Pointers, occupancy and flags. Flags are computed from the next count
    // so they always agree with the count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            count        <= '0;
            full         <= 1'b0;
            almost_full  <= 1'b0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= w_wr_ptr_next;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= w_rd_ptr_next;
            end
            count        <= w_count_next;
            full         <= (w_count_next == c_full_cnt);
            almost_full  <= (w_count_next >= c_af_cnt);
            empty        <= (w_count_next == '0);
            almost_empty <= (w_count_next <= c_ae_cnt);
            overflow     <= wr_en & full;
            underflow    <= rd_en & empty;
        end
    end

`ifdef FIFO_PARITY_EN
    // Extra MSB holds even parity, so the XOR over a stored entry is 0.
    assign w_mem_wr = {^wr_data, wr_data};
`else
    assign w_mem_wr = wr_data;
`endif

    fifo_mem #(
        .WIDTH  (c_mem_w),
        .DEPTH  (DEPTH),
        .ADDR_W (c_ptr_w)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (w_mem_wr),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_mem_rd)
    );

    if (FWFT != 0) begin : g_fwft
        // Head word is presented directly; zero while empty so the output
        // never shows stale or uninitialised storage.
        assign rd_valid = ~empty;
        assign rd_data  = empty ? '0 : w_mem_rd[DATA_W-1:0];
    end else begin : g_std
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_valid <= 1'b0;
                rd_data  <= '0;
            end else begin
                rd_valid <= w_rd_acc;
                if (w_rd_acc) begin
                    rd_data <= w_mem_rd[DATA_W-1:0];
                end
            end
        end
    end

`ifdef FIFO_PARITY_EN
    if (FWFT != 0) begin : g_perr_fwft
        assign rd_parity_err = ~empty & (^w_mem_rd);
    end else begin : g_perr_std
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_parity_err <= 1'b0;
            end else begin
                rd_parity_err <= w_rd_acc & (^w_mem_rd);
            end
        end
    end
`endif

endmodule : sync_fifo_param
`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo_param
// Purpose  : Self-checking bench for sync_fifo_param. Three instances:
//            u0 DEPTH=16 standard (AF=12, AE=3), u1 DEPTH=5 standard,
//            u2 DEPTH=16 first-word-fall-through. Each is compared every
//            cycle against a queue-style reference model.
// Macro    : FIFO_PARITY_EN - also exercises rd_parity_err.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_param;
    import fifo_pkg::*;

    localparam fifo_mode_e c_mode_u0 = FIFO_STD;
    localparam fifo_mode_e c_mode_u1 = FIFO_STD;
    localparam fifo_mode_e c_mode_u2 = FIFO_FWFT;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en [3];
    logic       rd_en [3];
    logic [7:0] wr_data [3];

    logic [7:0] w_rd_data [3];
    logic       w_rd_valid [3];
    logic       w_full [3];
    logic       w_afull [3];
    logic       w_empty [3];
    logic       w_aempty [3];
    logic       w_ovf [3];
    logic       w_unf [3];
    logic [4:0] w_count_u0;
    logic [2:0] w_count_u1;
    logic [4:0] w_count_u2;
`ifdef FIFO_PARITY_EN
    logic       w_perr [3];
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sync_fifo_param #(.DATA_W(8), .DEPTH(16), .AF_THRESH(12), .AE_THRESH(3), .FWFT(int'(c_mode_u0))) dut_a (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en[0]), .wr_data(wr_data[0]), .rd_en(rd_en[0]),
        .rd_data(w_rd_data[0]), .rd_valid(w_rd_valid[0]), .full(w_full[0]), .almost_full(w_afull[0]),
        .empty(w_empty[0]), .almost_empty(w_aempty[0]), .count(w_count_u0),
        .overflow(w_ovf[0]), .underflow(w_unf[0])
`ifdef FIFO_PARITY_EN
        , .rd_parity_err(w_perr[0])
`endif
    );

    sync_fifo_param #(.DATA_W(8), .DEPTH(5), .AF_THRESH(3), .AE_THRESH(1), .FWFT(int'(c_mode_u1))) dut_b (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en[1]), .wr_data(wr_data[1]), .rd_en(rd_en[1]),
        .rd_data(w_rd_data[1]), .rd_valid(w_rd_valid[1]), .full(w_full[1]), .almost_full(w_afull[1]),
        .empty(w_empty[1]), .almost_empty(w_aempty[1]), .count(w_count_u1),
        .overflow(w_ovf[1]), .underflow(w_unf[1])
`ifdef FIFO_PARITY_EN
        , .rd_parity_err(w_perr[1])
`endif
    );

    sync_fifo_param #(.DATA_W(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(int'(c_mode_u2))) dut_c (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en[2]), .wr_data(wr_data[2]), .rd_en(rd_en[2]),
        .rd_data(w_rd_data[2]), .rd_valid(w_rd_valid[2]), .full(w_full[2]), .almost_full(w_afull[2]),
        .empty(w_empty[2]), .almost_empty(w_aempty[2]), .count(w_count_u2),
        .overflow(w_ovf[2]), .underflow(w_unf[2])
`ifdef FIFO_PARITY_EN
        , .rd_parity_err(w_perr[2])
`endif
    );

    // ---------------- reference model ----------------
    // m_list[k][0] is the oldest stored word; m_cnt[k] words are valid.
    int         m_depth [3];
    int         m_af [3];
    int         m_ae [3];
    bit         m_fwft [3];
    logic [7:0] m_list [3][16];
    int         m_cnt [3];
    logic [7:0] m_rd_data [3];
    logic       m_rd_valid [3];
    logic       m_ovf [3];
    logic       m_unf [3];
    logic       m_perr [3];
    bit         m_head_bad [3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] get_count(input int k);
        case (k)
            0:       return 32'(w_count_u0);
            1:       return 32'(w_count_u1);
            default: return 32'(w_count_u2);
        endcase
    endfunction

    task automatic model_reset(input int k);
        m_cnt[k]      = 0;
        m_rd_data[k]  = 8'h00;
        m_rd_valid[k] = 1'b0;
        m_ovf[k]      = 1'b0;
        m_unf[k]      = 1'b0;
        m_perr[k]     = 1'b0;
        m_head_bad[k] = 1'b0;
    endtask

    // Applies one clock edge worth of behaviour using the inputs seen at it.
    task automatic model_step(input int k);
        bit wa;
        bit ra;
        wa = wr_en[k] && (m_cnt[k] != m_depth[k]);
        ra = rd_en[k] && (m_cnt[k] != 0);
        m_ovf[k] = wr_en[k] && (m_cnt[k] == m_depth[k]);
        m_unf[k] = rd_en[k] && (m_cnt[k] == 0);
        if (!m_fwft[k]) begin
            m_rd_valid[k] = ra;
            m_perr[k]     = ra && m_head_bad[k];
            if (ra) m_rd_data[k] = m_list[k][0];
        end
        if (ra) begin
            for (int i = 0; i < 15; i++) m_list[k][i] = m_list[k][i+1];
            m_cnt[k]--;
            m_head_bad[k] = 1'b0;
        end
        if (wa) begin
            m_list[k][m_cnt[k]] = wr_data[k];
            m_cnt[k]++;
        end
    endtask

    task automatic check_all(input int k);
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_perr;
        if (m_fwft[k]) begin
            exp_valid = (m_cnt[k] != 0);
            exp_data  = (m_cnt[k] != 0) ? m_list[k][0] : 8'h00;
            exp_perr  = (m_cnt[k] != 0) && m_head_bad[k];
        end else begin
            exp_valid = m_rd_valid[k];
            exp_data  = m_rd_data[k];
            exp_perr  = m_perr[k];
        end
        chk($sformatf("u%0d.count", k), get_count(k), 32'(m_cnt[k]));
        chk($sformatf("u%0d.full", k), 32'(w_full[k]), 32'(m_cnt[k] == m_depth[k]));
        chk($sformatf("u%0d.empty", k), 32'(w_empty[k]), 32'(m_cnt[k] == 0));
        chk($sformatf("u%0d.almost_full", k), 32'(w_afull[k]), 32'(m_cnt[k] >= m_af[k]));
        chk($sformatf("u%0d.almost_empty", k), 32'(w_aempty[k]), 32'(m_cnt[k] <= m_ae[k]));
        chk($sformatf("u%0d.overflow", k), 32'(w_ovf[k]), 32'(m_ovf[k]));
        chk($sformatf("u%0d.underflow", k), 32'(w_unf[k]), 32'(m_unf[k]));
        chk($sformatf("u%0d.rd_valid", k), 32'(w_rd_valid[k]), 32'(exp_valid));
        chk($sformatf("u%0d.rd_data", k), 32'(w_rd_data[k]), 32'(exp_data));
`ifdef FIFO_PARITY_EN
        chk($sformatf("u%0d.rd_parity_err", k), 32'(w_perr[k]), 32'(exp_perr));
`else
        if (exp_perr) chk($sformatf("u%0d.model_perr", k), 32'(exp_perr), 32'd0);
`endif
    endtask

    // One clock: model follows the edge, outputs compared 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        for (int k = 0; k < 3; k++) model_step(k);
        #1;
        for (int k = 0; k < 3; k++) check_all(k);
    endtask

    task automatic idle_all();
        for (int k = 0; k < 3; k++) begin
            wr_en[k]   = 1'b0;
            rd_en[k]   = 1'b0;
            wr_data[k] = 8'h00;
        end
    endtask

    task automatic push(input int k, input logic [7:0] d);
        idle_all();
        wr_en[k] = 1'b1;
        wr_data[k] = d;
        cycle();
    endtask

    task automatic pop(input int k);
        idle_all();
        rd_en[k] = 1'b1;
        cycle();
    endtask

    // Reset asserted between clock edges; outputs must change without an edge.
    task automatic async_reset();
        idle_all();
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) model_reset(k);
        for (int k = 0; k < 3; k++) check_all(k);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 3; k++) check_all(k);
    endtask

    initial begin
        int bias_w [3];
        m_depth = '{16, 5, 16};
        m_af    = '{12, 3, 14};
        m_ae    = '{3, 1, 2};
        m_fwft  = '{c_mode_u0 == FIFO_FWFT, c_mode_u1 == FIFO_FWFT, c_mode_u2 == FIFO_FWFT};
        idle_all();
        for (int k = 0; k < 3; k++) model_reset(k);

        // Reset state
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) check_all(k);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Fill/drain on u0: 16 writes, one overflowing write, 16 reads
        for (int i = 0; i < 16; i++) push(0, 8'(i));
        chk("fill.full", 32'(w_full[0]), 32'd1);
        chk("fill.count", 32'(w_count_u0), 32'd16);
        push(0, 8'hEE);
        chk("fill.overflow", 32'(w_ovf[0]), 32'd1);
        idle_all();
        cycle();
        chk("fill.overflow_clear", 32'(w_ovf[0]), 32'd0);
        for (int i = 0; i < 16; i++) begin
            pop(0);
            chk("drain.data", 32'(w_rd_data[0]), 32'(i));
        end
        idle_all();
        cycle();
        chk("drain.empty", 32'(w_empty[0]), 32'd1);

        // Wrap-around on u1 (DEPTH=5)
        for (int i = 0; i < 3; i++) push(1, 8'(8'h10 + i));
        for (int i = 0; i < 3; i++) pop(1);
        for (int i = 0; i < 5; i++) push(1, 8'(8'hA0 + i));
        chk("wrap.full", 32'(w_full[1]), 32'd1);
        for (int i = 0; i < 5; i++) begin
            pop(1);
            chk("wrap.data", 32'(w_rd_data[1]), 32'(8'hA0 + i));
        end

        // Simultaneous read/write on u0 at count=8, then at empty
        for (int i = 0; i < 8; i++) push(0, 8'(8'h80 + i));
        for (int i = 0; i < 10; i++) begin
            idle_all();
            wr_en[0] = 1'b1; rd_en[0] = 1'b1; wr_data[0] = 8'(8'h90 + i);
            cycle();
            chk("simul.count", 32'(w_count_u0), 32'd8);
        end
        for (int i = 0; i < 8; i++) pop(0);
        idle_all();
        wr_en[0] = 1'b1; rd_en[0] = 1'b1; wr_data[0] = 8'h77;
        cycle();
        chk("simul_empty.underflow", 32'(w_unf[0]), 32'd1);
        chk("simul_empty.count", 32'(w_count_u0), 32'd1);
        pop(0);

        // FWFT single word on u2
        push(2, 8'h5A);
        chk("fwft.data", 32'(w_rd_data[2]), 32'h5A);
        chk("fwft.valid", 32'(w_rd_valid[2]), 32'd1);
        pop(2);
        chk("fwft.empty", 32'(w_empty[2]), 32'd1);
        chk("fwft.valid_clear", 32'(w_rd_valid[2]), 32'd0);

        // Randomized traffic with phases biased toward filling or draining
        for (int c = 0; c < 2400; c++) begin
            if (c % 150 == 0) begin
                for (int k = 0; k < 3; k++) bias_w[k] = (($urandom_range(0, 1) == 0) ? 25 : 75);
            end
            for (int k = 0; k < 3; k++) begin
                wr_en[k]   = ($urandom_range(0, 99) < bias_w[k]);
                rd_en[k]   = ($urandom_range(0, 99) < (100 - bias_w[k]));
                wr_data[k] = 8'($urandom_range(0, 255));
            end
            cycle();
        end

        // Reset mid-operation at count=7
        async_reset();
        for (int i = 0; i < 7; i++) push(0, 8'(8'h40 + i));
        chk("midrst.count_before", 32'(w_count_u0), 32'd7);
        async_reset();
        chk("midrst.count_after", 32'(w_count_u0), 32'd0);
        push(0, 8'h3C);
        pop(0);
        chk("midrst.new_data", 32'(w_rd_data[0]), 32'h3C);
        idle_all();
        cycle();

`ifdef FIFO_PARITY_EN
        // Flip the stored parity bit of entry 0 and read it back
        async_reset();
        push(0, 8'h55);
        dut_a.u_mem.r_mem[0][8] = ~dut_a.u_mem.r_mem[0][8];
        m_head_bad[0] = 1'b1;
        pop(0);
        chk("parity.err", 32'(w_perr[0]), 32'd1);
        idle_all();
        cycle();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_sync_fifo_param
`default_nettype wire
